pixel_line_fifo: RTL and testbench

- Single-clock first-word-fall-through pixel FIFO sitting directly upstream of the HDMI debug timing generator.
- Accepts 12-bit RGB444 pixels from the camera capture path with a valid/ready handshake and start-of-frame marker.
- Serves them on the generator's Mem_Read/Mem_Data interface with zero read latency.
- Aligns camera frames to the display's VSync and recovers from underflow by flushing and re-hunting for start of frame.

---
 rtl/pixel_line_fifo_if.sv | 27 ++
 rtl/pixel_line_fifo.sv | 125 ++++++++++++
 tb/tb_pixel_line_fifo.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_line_fifo_if.sv
// Pixel FIFO bus: camera-side valid/ready stream, generator-side Mem_Read/Mem_Data
// port and status outputs.
interface pixel_line_fifo_if #(
    parameter int DW = 12,
    parameter int AW = 11
);
    logic          In_Valid;
    logic [DW-1:0] In_Data;
    logic          In_SOF;
    logic          In_Ready;
    logic          Out_VSync;
    logic          Mem_Read;
    logic [DW-1:0] Mem_Data;
    logic [AW:0]   Fifo_Level;
    logic [1:0]    Sts_State;
    logic [15:0]   Underflow_Cnt;

    modport slave (
        input  In_Valid, In_Data, In_SOF, Out_VSync, Mem_Read,
        output In_Ready, Mem_Data, Fifo_Level, Sts_State, Underflow_Cnt
    );

    modport master (
        output In_Valid, In_Data, In_SOF, Out_VSync, Mem_Read,
        input  In_Ready, Mem_Data, Fifo_Level, Sts_State, Underflow_Cnt
    );
endinterface

// File: rtl/pixel_line_fifo.sv
// First-word-fall-through pixel FIFO feeding the HDMI timing generator; aligns
// camera frames to display VSync and re-hunts for start of frame after underflow.
module pixel_line_fifo #(
    parameter int DW          = 12,
    parameter int AW          = 11,
    parameter int PRIME_LEVEL = 1280
) (
    input  logic             clk,
    input  logic             rstn,
    pixel_line_fifo_if.slave bus
);
    localparam int DEPTH = 2 ** AW;
    localparam logic [AW:0] LVL_FULL  = (AW + 1)'(DEPTH);
    localparam logic [AW:0] LVL_PRIME = (AW + 1)'(PRIME_LEVEL);

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic [15:0]   r_underflow_cnt;
    logic          r_vs_d;
    logic [DW-1:0] r_mem [DEPTH];

    logic          w_vs_fall;
    logic          w_full;
    logic          w_empty;
    logic          w_ready;
    logic          w_accept;
    logic          w_pop;
    logic          w_underflow;
    logic          w_flush;
    logic          w_wr_en;
    logic [AW-1:0] w_wr_addr;

    always_comb begin
        w_vs_fall   = r_vs_d && !bus.Out_VSync;
        w_full      = (r_level == LVL_FULL);
        w_empty     = (r_level == '0);
        w_ready     = rstn && ((r_state == ST_HUNT) || !w_full);
        w_accept    = bus.In_Valid && w_ready;
        w_underflow = (r_state == ST_RUN) && bus.Mem_Read && w_empty;
        w_pop       = (r_state == ST_RUN) && bus.Mem_Read && !w_empty;
        // SOF restarts the frame at address 0 until the FIFO is running.
        w_flush     = w_accept && bus.In_SOF &&
                      ((r_state == ST_HUNT) || (r_state == ST_PRIME));
        w_wr_en     = w_flush ||
                      (w_accept && ((r_state == ST_PRIME) ||
                                    ((r_state == ST_RUN) && !w_underflow)));
        w_wr_addr   = w_flush ? '0 : r_wr_ptr;
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= bus.In_Data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state         <= ST_HUNT;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_level         <= '0;
            r_underflow_cnt <= '0;
            r_vs_d          <= 1'b1;
        end else begin
            r_vs_d <= bus.Out_VSync;
            case (r_state)
                ST_HUNT, ST_PRIME: begin
                    if (w_flush) begin
                        // A fresh SOF wins over a coincident VSync: the new frame must prime again.
                        r_wr_ptr <= AW'(1);
                        r_rd_ptr <= '0;
                        r_level  <= (AW + 1)'(1);
                        r_state  <= ST_PRIME;
                    end else if (r_state == ST_PRIME) begin
                        if (w_accept) begin
                            r_wr_ptr <= r_wr_ptr + AW'(1);
                            r_level  <= r_level + (AW + 1)'(1);
                        end
                        if (w_vs_fall && (r_level >= LVL_PRIME)) begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_underflow) begin
                        r_wr_ptr <= '0;
                        r_rd_ptr <= '0;
                        r_level  <= '0;
                        r_state  <= ST_HUNT;
                        if (r_underflow_cnt != 16'hFFFF) begin
                            r_underflow_cnt <= r_underflow_cnt + 16'd1;
                        end
                    end else begin
                        if (w_wr_en) begin
                            r_wr_ptr <= r_wr_ptr + AW'(1);
                        end
                        if (w_pop) begin
                            r_rd_ptr <= r_rd_ptr + AW'(1);
                        end
                        if (w_wr_en && !w_pop) begin
                            r_level <= r_level + (AW + 1)'(1);
                        end else if (w_pop && !w_wr_en) begin
                            r_level <= r_level - (AW + 1)'(1);
                        end
                    end
                end
                default: r_state <= ST_HUNT;
            endcase
        end
    end

    assign bus.In_Ready      = w_ready;
    assign bus.Mem_Data      = (rstn && (r_state == ST_RUN) && !w_empty) ? r_mem[r_rd_ptr] : '0;
    assign bus.Fifo_Level    = r_level;
    assign bus.Sts_State     = r_state;
    assign bus.Underflow_Cnt = r_underflow_cnt;
endmodule

// File: tb/tb_pixel_line_fifo.sv
// Directed bench for pixel_line_fifo: queue-based reference model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_pixel_line_fifo;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    pixel_line_fifo_if #(.DW(12), .AW(11)) bus ();

    pixel_line_fifo #(.DW(12), .AW(11), .PRIME_LEVEL(1280)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: contents as a queue, state as a plain integer.
    logic [11:0] mq[$];
    int          m_state = 0;
    int          m_ucnt = 0;
    bit          m_vs_d = 1'b1;

    initial begin : model
        bit fall, rdy, acc;
        int exp_rdy, exp_data;
        @(posedge clk);
        forever begin
            @(negedge clk);
            exp_rdy  = !rstn ? 0 : ((m_state == 0) ? 1 : int'(mq.size() != 2048));
            exp_data = (rstn && m_state == 2 && mq.size() != 0) ? int'(mq[0]) : 0;
            check("mdl_ready", int'(bus.In_Ready), exp_rdy);
            check("mdl_data", int'(bus.Mem_Data), exp_data);
            check("mdl_level", int'(bus.Fifo_Level), mq.size());
            check("mdl_state", int'(bus.Sts_State), m_state);
            check("mdl_ucnt", int'(bus.Underflow_Cnt), m_ucnt);
            // Inputs are stable from here until the next rising edge samples them.
            if (!rstn) begin
                mq.delete();
                m_state = 0;
                m_ucnt  = 0;
                m_vs_d  = 1'b1;
            end else begin
                fall   = m_vs_d && !bus.Out_VSync;
                m_vs_d = bus.Out_VSync;
                rdy    = (exp_rdy != 0);
                acc    = bus.In_Valid && rdy;
                case (m_state)
                    0: if (acc && bus.In_SOF) begin
                        mq = {bus.In_Data};
                        m_state = 1;
                    end
                    1: if (acc && bus.In_SOF) begin
                        mq = {bus.In_Data};
                    end else begin
                        if (fall && mq.size() >= 1280) m_state = 2;
                        if (acc) mq.push_back(bus.In_Data);
                    end
                    default: if (bus.Mem_Read && mq.size() == 0) begin
                        if (m_ucnt != 16'hFFFF) m_ucnt++;
                        m_state = 0;
                    end else begin
                        if (bus.Mem_Read) void'(mq.pop_front());
                        if (acc) mq.push_back(bus.In_Data);
                    end
                endcase
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bus.In_Valid  = 1'b0;
        bus.In_Data   = '0;
        bus.In_SOF    = 1'b0;
        bus.Out_VSync = 1'b1;
        bus.Mem_Read  = 1'b0;
        rstn = 1'b0;
        tick();
        tick();
        check("rst_ready", int'(bus.In_Ready), 0);
        check("rst_data", int'(bus.Mem_Data), 0);
        check("rst_level", int'(bus.Fifo_Level), 0);
        check("rst_state", int'(bus.Sts_State), 0);
        rstn = 1'b1;
        tick();

        // HUNT discards non-SOF pixels
        bus.In_Valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.In_Data = 12'(i);
            tick();
        end
        check("hunt_level", int'(bus.Fifo_Level), 0);
        check("hunt_state", int'(bus.Sts_State), 0);
        check("hunt_ready", int'(bus.In_Ready), 1);
        bus.In_Data = 12'hABC;
        bus.In_SOF  = 1'b1;
        tick();
        bus.In_SOF   = 1'b0;
        bus.In_Valid = 1'b0;
        check("sof_state", int'(bus.Sts_State), 1);
        check("sof_level", int'(bus.Fifo_Level), 1);

        // Second SOF flushes, then short prime ignores VSync
        bus.In_Valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            bus.In_Data = 12'(i);
            bus.In_SOF  = (i == 0);
            tick();
            if (i == 0) check("reflush_level", int'(bus.Fifo_Level), 1);
        end
        bus.In_SOF   = 1'b0;
        bus.In_Valid = 1'b0;
        check("prime1000_level", int'(bus.Fifo_Level), 1000);
        bus.Out_VSync = 1'b0;
        tick();
        bus.Out_VSync = 1'b1;
        check("short_prime_state", int'(bus.Sts_State), 1);
        tick();
        bus.In_Valid = 1'b1;
        for (int i = 1000; i < 1280; i++) begin
            bus.In_Data = 12'(i);
            tick();
        end
        bus.In_Valid = 1'b0;
        check("prime1280_level", int'(bus.Fifo_Level), 1280);
        bus.Out_VSync = 1'b0;
        tick();
        bus.Out_VSync = 1'b1;
        check("run_state", int'(bus.Sts_State), 2);

        // Zero-latency reads of the first line
        bus.Mem_Read = 1'b1;
        for (int i = 0; i < 640; i++) begin
            check("line0_data", int'(bus.Mem_Data), i);
            tick();
        end
        bus.Mem_Read = 1'b0;
        check("line0_level", int'(bus.Fifo_Level), 640);

        // Drain then underflow
        bus.Mem_Read = 1'b1;
        for (int i = 0; i < 640; i++) begin
            check("line1_data", int'(bus.Mem_Data), 640 + i);
            tick();
        end
        check("empty_level", int'(bus.Fifo_Level), 0);
        check("empty_data", int'(bus.Mem_Data), 0);
        check("empty_state", int'(bus.Sts_State), 2);
        check("empty_ucnt", int'(bus.Underflow_Cnt), 0);
        tick();
        bus.Mem_Read = 1'b0;
        check("uf_ucnt", int'(bus.Underflow_Cnt), 1);
        check("uf_state", int'(bus.Sts_State), 0);
        check("uf_level", int'(bus.Fifo_Level), 0);
        check("uf_data", int'(bus.Mem_Data), 0);

        // Fill to full, then simultaneous read/write across the pointer wrap
        bus.In_Valid = 1'b1;
        for (int k = 0; k < 2048; k++) begin
            bus.In_Data = 12'(k);
            bus.In_SOF  = (k == 0);
            check("fill_ready", int'(bus.In_Ready), 1);
            tick();
        end
        bus.In_SOF  = 1'b0;
        bus.In_Data = 12'hFFF;
        check("full_level", int'(bus.Fifo_Level), 2048);
        check("full_ready", int'(bus.In_Ready), 0);
        tick();
        check("full_hold_level", int'(bus.Fifo_Level), 2048);
        bus.Out_VSync = 1'b0;
        tick();
        bus.Out_VSync = 1'b1;
        check("full_run_state", int'(bus.Sts_State), 2);
        bus.Mem_Read = 1'b1;
        for (int c = 0; c < 100; c++) begin
            bus.In_Data = 12'(2048 + c);
            check("rw_data", int'(bus.Mem_Data), c);
            tick();
            check("rw_level", int'(bus.Fifo_Level), 2047);
        end
        bus.In_Valid = 1'b0;
        for (int c = 100; c < 2048; c++) begin
            check("drain_data", int'(bus.Mem_Data), c);
            tick();
        end
        for (int c = 1; c < 100; c++) begin
            check("wrap_data", int'(bus.Mem_Data), 2048 + c);
            tick();
        end
        bus.Mem_Read = 1'b0;
        check("drained_level", int'(bus.Fifo_Level), 0);

        // Reset mid-RUN with 500 stored
        bus.In_Valid = 1'b1;
        for (int i = 0; i < 500; i++) begin
            bus.In_Data = 12'(3000 + i);
            tick();
        end
        bus.In_Valid = 1'b0;
        check("pre_rst_level", int'(bus.Fifo_Level), 500);
        check("pre_rst_state", int'(bus.Sts_State), 2);
        check("pre_rst_head", int'(bus.Mem_Data), 3000);
        rstn = 1'b0;
        tick();
        check("mid_rst_level", int'(bus.Fifo_Level), 0);
        check("mid_rst_state", int'(bus.Sts_State), 0);
        check("mid_rst_ucnt", int'(bus.Underflow_Cnt), 0);
        check("mid_rst_ready", int'(bus.In_Ready), 0);
        rstn = 1'b1;
        tick();
        check("post_rst_ready", int'(bus.In_Ready), 1);
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
